// File: rtl/fifo_rd_pkg.sv
// Shared defaults and derived widths for the FIFO drain-side packer.
// Used by fifo_rd_skid, fifo_rd_packer_if and fifo_rd_packer.
package fifo_rd_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int PACK_NUM_DEF   = 4;
  localparam int SKID_DEPTH_DEF = 4;

  localparam int PACK_IDX_W = $clog2(PACK_NUM_DEF);
  localparam int SKID_PTR_W = $clog2(SKID_DEPTH_DEF);
  localparam int OUT_CNT_W  = PACK_IDX_W + 1;

  // FILL: gathering FIFO words into slots; HOLD: complete (or flushed) word offered downstream.
  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } pack_state_e;

endpackage

// File: rtl/fifo_rd_packer_if.sv
// FIFO read-port and packed-output handshake bundle for fifo_rd_packer.
// flush/out_cnt exist only when FIFO_RD_PACKER_FLUSH_EN is defined.
interface fifo_rd_packer_if
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int PACK_NUM   = PACK_NUM_DEF
);

  logic                           fifo_empty;
  logic                           fifo_rd_en;
  logic                           fifo_valid;
  logic [DATA_WIDTH-1:0]          fifo_dout;
  logic                           out_valid;
  logic                           out_ready;
  logic [DATA_WIDTH*PACK_NUM-1:0] out_data;
`ifdef FIFO_RD_PACKER_FLUSH_EN
  localparam int CNT_W = $clog2(PACK_NUM) + 1;
  logic                           flush;
  logic [CNT_W-1:0]               out_cnt;
`endif

  // The packer drives the pop request and the packed output stream.
  modport master (
    input  fifo_empty, fifo_valid, fifo_dout, out_ready,
    output fifo_rd_en, out_valid, out_data
`ifdef FIFO_RD_PACKER_FLUSH_EN
    , input flush, output out_cnt
`endif
  );

  modport slave (
    output fifo_empty, fifo_valid, fifo_dout, out_ready,
    input  fifo_rd_en, out_valid, out_data
`ifdef FIFO_RD_PACKER_FLUSH_EN
    , output flush, input out_cnt
`endif
  );

endinterface

// File: rtl/fifo_rd_skid.sv
// Small single-clock FIFO that absorbs the one-cycle FIFO read latency.
// Synchronous active-high reset; combinational read of the head entry.
module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = SKID_DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [DATA_WIDTH-1:0]  din,
  input  logic                   pop,
  output logic [DATA_WIDTH-1:0]  dout,
  output logic [$clog2(DEPTH):0] occ,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [PTR_W:0]        occ_q;
  logic                  full;

  // NOTE: storage is deliberately not reset; occ_q alone says which entries are live, so stale data is never read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= din;
  end

  // NOTE: all registered state uses non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign dout  = mem[rd_ptr_q];
  assign occ   = occ_q;
  assign empty = (occ_q == '0);
  assign full  = (occ_q == (PTR_W+1)'(DEPTH));

  // The pop throttle upstream reserves a slot for every in-flight read.
  a_no_overflow:  assert property (@(posedge clk) disable iff (rst) !(push && full));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop && empty));

endmodule

// File: rtl/fifo_rd_packer.sv
// Drain-side controller for the async FIFO read port: pops, skid-buffers and packs
// PACK_NUM words per output beat. FIFO_RD_PACKER_FLUSH_EN adds flush/out_cnt.
module fifo_rd_packer
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int PACK_NUM   = PACK_NUM_DEF,
  parameter int SKID_DEPTH = SKID_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  fifo_rd_packer_if.master  bus
);

  localparam int IDX_W  = $clog2(PACK_NUM);
  localparam int SKID_W = $clog2(SKID_DEPTH);
  localparam int OUT_W  = DATA_WIDTH * PACK_NUM;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PACK_NUM - 1);

  logic                  rd_pend_q;
  logic                  skid_push;
  logic                  skid_empty;
  logic [DATA_WIDTH-1:0] skid_dout;
  logic [SKID_W:0]       skid_occ;
  logic [SKID_W+1:0]     occ_sum;

  pack_state_e           state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [OUT_W-1:0]      data_q, data_d;
  logic                  drain;
  logic                  pack_en;
  logic                  flush_fire;

  // Reserve a skid slot for the pop still in flight so the skid can never overflow.
  assign occ_sum        = {1'b0, skid_occ} + (SKID_W+2)'(rd_pend_q);
  assign bus.fifo_rd_en = !rst && !bus.fifo_empty && (occ_sum < (SKID_W+2)'(SKID_DEPTH));

  // Only data answering one of our own pops is accepted; a read in flight across reset is dropped.
  assign skid_push = bus.fifo_valid && rd_pend_q;

  fifo_rd_skid #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (SKID_DEPTH)
  ) u_skid (
    .clk   (clk),
    .rst   (rst),
    .push  (skid_push),
    .din   (bus.fifo_dout),
    .pop   (pack_en),
    .dout  (skid_dout),
    .occ   (skid_occ),
    .empty (skid_empty)
  );

`ifdef FIFO_RD_PACKER_FLUSH_EN
  assign flush_fire = bus.flush && (idx_q != '0) && (state_q == ST_FILL);
`else
  assign flush_fire = 1'b0;
`endif

  assign drain   = (state_q == ST_HOLD) && bus.out_ready;
  assign pack_en = !skid_empty && ((state_q == ST_FILL) || drain) && !flush_fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend_q <= 1'b0;
      state_q   <= ST_FILL;
      idx_q     <= '0;
      data_q    <= '0;
    end else begin
      rd_pend_q <= bus.fifo_rd_en;
      state_q   <= state_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;

    if (drain) state_d = ST_HOLD == state_q ? ST_FILL : state_q;

    if (flush_fire) begin
      state_d = ST_HOLD;
      idx_d   = '0;
    end

    if (pack_en) begin
      // Starting a new word clears every slot, so unfilled slots read as zero on a flush.
      if (idx_q == '0) data_d = '0;
      for (int s = 0; s < PACK_NUM; s++) begin
        if (idx_q == IDX_W'(s)) data_d[s*DATA_WIDTH +: DATA_WIDTH] = skid_dout;
      end
      idx_d = idx_q + 1'b1;
      if (idx_q == LAST_IDX) state_d = ST_HOLD;
    end
  end

  assign bus.out_valid = (state_q == ST_HOLD);
  assign bus.out_data  = data_q;

`ifdef FIFO_RD_PACKER_FLUSH_EN
  logic [IDX_W:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (flush_fire) begin
      cnt_q <= {1'b0, idx_q};
    end else if (pack_en && (idx_q == LAST_IDX)) begin
      cnt_q <= (IDX_W+1)'(PACK_NUM);
    end
  end

  assign bus.out_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer: behavioural FIFO with 1-cycle read latency,
// output collector, hand-computed expected packed words.
module tb_fifo_rd_packer;
  import fifo_rd_pkg::*;

  localparam int DW = DATA_WIDTH_DEF;
  localparam int PN = PACK_NUM_DEF;
  localparam int OW = DW * PN;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_rd_packer_if #(.DATA_WIDTH(DW), .PACK_NUM(PN)) bus ();

  fifo_rd_packer #(
    .DATA_WIDTH (DW),
    .PACK_NUM   (PN),
    .SKID_DEPTH (SKID_DEPTH_DEF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int                   n_checks = 0;
  int                   n_errors = 0;
  int                   cyc = 0;
  int                   pops = 0;
  bit                   stall_empty = 1'b0;
  bit                   pop_on_empty = 1'b0;
  bit                   hold_bad = 1'b0;
  logic [SKID_PTR_W:0]  max_occ = '0;
  logic [DW-1:0]        fifo_q[$];
  logic [OW-1:0]        got[$];
  int                   got_cyc[$];
  logic [OUT_CNT_W-1:0] got_cnt[$];

  task automatic check(input string tag, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [OW-1:0] got_at(input int i);
    if (i < got.size()) return got[i];
    return '0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_got();
    got.delete();
    got_cyc.delete();
    got_cnt.delete();
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural FIFO read port: data and valid appear one cycle after an accepted pop.
  initial begin
    bit take;
    bus.fifo_empty = 1'b1;
    bus.fifo_valid = 1'b0;
    bus.fifo_dout  = '0;
    forever begin
      @(negedge clk);
      if (bus.fifo_rd_en && bus.fifo_empty) pop_on_empty = 1'b1;
      take = bus.fifo_rd_en && (fifo_q.size() > 0);
      @(posedge clk);
      #2;
      if (take) begin
        bus.fifo_dout  = fifo_q.pop_front();
        bus.fifo_valid = 1'b1;
        pops++;
      end else begin
        bus.fifo_valid = 1'b0;
      end
      bus.fifo_empty = stall_empty || (fifo_q.size() == 0);
    end
  end

  // Output collector plus hold-stability and skid-occupancy watch.
  initial begin
    bit            prev_hold = 1'b0;
    logic [OW-1:0] prev_data = '0;
    forever begin
      @(negedge clk);
      if (dut.skid_occ > max_occ) max_occ = dut.skid_occ;
      if (prev_hold && !rst && (!bus.out_valid || bus.out_data !== prev_data)) hold_bad = 1'b1;
      prev_hold = bus.out_valid && !bus.out_ready && !rst;
      prev_data = bus.out_data;
      if (!rst && bus.out_valid && bus.out_ready) begin
        got.push_back(bus.out_data);
        got_cyc.push_back(cyc);
`ifdef FIFO_RD_PACKER_FLUSH_EN
        got_cnt.push_back(bus.out_cnt);
`endif
      end
    end
  end

  initial begin
    int            base;
    logic [OW-1:0] exp2 [4];
    logic [OW-1:0] exp3 [$];
    logic [OW-1:0] cur;
    logic [DW-1:0] w;

    rst           = 1'b1;
    bus.out_ready = 1'b0;
`ifdef FIFO_RD_PACKER_FLUSH_EN
    bus.flush     = 1'b0;
`endif
    repeat (2) tick();

    // Reset state with a non-empty FIFO: no pop while rst is high.
    for (int i = 1; i <= 8; i++) fifo_q.push_back(DW'(i));
    tick();
    @(negedge clk);
    check("rst_rd_en", OW'(bus.fifo_rd_en), '0);
    check("rst_out_valid", OW'(bus.out_valid), '0);
    check("rst_out_data", bus.out_data, '0);

    // Test 1: 8 preloaded words, consumer always ready.
    tick();
    base          = pops;
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    repeat (20) tick();
    check("t1_count", OW'(got.size()), OW'(2));
    check("t1_word0", got_at(0), 64'h0004_0003_0002_0001);
    check("t1_word1", got_at(1), 64'h0008_0007_0006_0005);
    check("t1_spacing", OW'(got.size() >= 2 ? got_cyc[1] - got_cyc[0] : 0), OW'(PN));
    check("t1_pops", OW'(pops - base), OW'(8));

    // Test 2: consumer stalled with 16 words queued.
    clear_got();
    bus.out_ready = 1'b0;
    base          = pops;
    for (int i = 0; i < 16; i++) fifo_q.push_back(DW'(16'h0011 + i));
    repeat (20) tick();
    @(negedge clk);
    check("t2_pops_stalled", OW'(pops - base), OW'(SKID_DEPTH_DEF + PN));
    check("t2_rd_en_low", OW'(bus.fifo_rd_en), '0);
    check("t2_out_valid", OW'(bus.out_valid), OW'(1));
    check("t2_out_data_held", bus.out_data, 64'h0014_0013_0012_0011);
    check("t2_skid_full", OW'(dut.skid_occ), OW'(SKID_DEPTH_DEF));
    tick();
    bus.out_ready = 1'b1;
    repeat (30) tick();
    exp2[0] = 64'h0014_0013_0012_0011;
    exp2[1] = 64'h0018_0017_0016_0015;
    exp2[2] = 64'h001C_001B_001A_0019;
    exp2[3] = 64'h0020_001F_001E_001D;
    check("t2_count", OW'(got.size()), OW'(4));
    for (int i = 0; i < 4; i++) check($sformatf("t2_word%0d", i), got_at(i), exp2[i]);
    check("t2_pops_total", OW'(pops - base), OW'(16));

    // Test 3: random empty/ready toggling over 1000 words.
    clear_got();
    cur = '0;
    for (int i = 0; i < 1000; i++) begin
      w = DW'($urandom);
      fifo_q.push_back(w);
      cur[(i % PN)*DW +: DW] = w;
      if ((i % PN) == PN - 1) exp3.push_back(cur);
    end
    for (int c = 0; c < 20000 && got.size() < 250; c++) begin
      stall_empty   = ($urandom_range(0, 3) == 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    stall_empty   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (10) tick();
    check("t3_count", OW'(got.size()), OW'(250));
    for (int i = 0; i < 250; i++) check($sformatf("t3_word%0d", i), got_at(i), exp3[i]);
    check("t3_skid_bound", OW'(max_occ <= SKID_DEPTH_DEF), OW'(1));
    check("t3_fifo_drained", OW'(fifo_q.size()), '0);

    // Test 4: reset pulse with two words packed, one in the skid, one read in flight.
    clear_got();
    for (int i = 0; i < 6; i++) fifo_q.push_back(DW'(16'h0031 + i));
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t4_out_valid", OW'(bus.out_valid), '0);
    check("t4_out_data", bus.out_data, '0);
    tick();
    fifo_q.push_back(16'h0037);
    fifo_q.push_back(16'h0038);
    repeat (15) tick();
    check("t4_count", OW'(got.size()), OW'(1));
    check("t4_word", got_at(0), 64'h0038_0037_0036_0035);

`ifdef FIFO_RD_PACKER_FLUSH_EN
    // Test 5: flush a 3-word partial.
    clear_got();
    fifo_q.push_back(16'h000A);
    fifo_q.push_back(16'h000B);
    fifo_q.push_back(16'h000C);
    repeat (8) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    repeat (4) tick();
    check("t5_count", OW'(got.size()), OW'(1));
    check("t5_word", got_at(0), 64'h0000_000C_000B_000A);
    check("t5_cnt", OW'(got_cnt.size() > 0 ? got_cnt[0] : '0), OW'(3));

    // Test 6: flush with idx=0 is ignored; flush behind a stalled full word changes nothing.
    clear_got();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    repeat (4) tick();
    check("t6_idle_flush", OW'(got.size()), '0);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) fifo_q.push_back(DW'(16'h0061 + i));
    repeat (10) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    repeat (3) tick();
    bus.out_ready = 1'b1;
    repeat (5) tick();
    check("t6_count", OW'(got.size()), OW'(1));
    check("t6_word", got_at(0), 64'h0064_0063_0062_0061);
    check("t6_cnt", OW'(got_cnt.size() > 0 ? got_cnt[0] : '0), OW'(PN));
`endif

    check("no_pop_on_empty", OW'(pop_on_empty), '0);
    check("hold_stable", OW'(hold_bad), '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
